// File: rtl/fp_mult_if.sv
// rtl/fp_mult_if.sv - start/busy/done handshake bundle for the floating-point multiplier
//
// Purpose: groups the operand request and the result/flag response of
// fp_mult_param so requester and multiplier connect through one port.
// Signals:
//   start     request, sampled only while the multiplier is idle
//   rnd_mode  0 = round-nearest-even, 1 = truncate toward zero
//   a_in      operand A (W bits, IEEE-754 layout)
//   b_in      operand B (W bits, IEEE-754 layout)
//   result    product, held until the next accepted operation
//   flags     {invalid, overflow, underflow, inexact, zero}
//   busy      high while an operation is in flight
//   done      one-cycle pulse, result/flags valid
// Modports: master drives the request, slave is the multiplier.

interface fp_mult_if #(
  parameter int W = 32
) ();
  logic         start;
  logic         rnd_mode;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] result;
  logic [4:0]   flags;
  logic         busy;
  logic         done;

  modport master (
    output start, rnd_mode, a_in, b_in,
    input  result, flags, busy, done
  );

  modport slave (
    input  start, rnd_mode, a_in, b_in,
    output result, flags, busy, done
  );
endinterface

// File: rtl/fp_mult_param.sv
// rtl/fp_mult_param.sv - parametrised multi-cycle IEEE-754 floating-point multiplier
//
// Purpose: fixed 4-cycle multiplier for EXP_W/MAN_W generic formats
// (8/23 = binary32, 5/10 = binary16). Subnormal inputs are flushed to zero,
// underflowing results are flushed to signed zero, and overflow returns
// infinity in both rounding modes.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fp_mult_if.slave: start, rnd_mode, a_in, b_in in;
//          result, flags, busy, done out

module fp_mult_param #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  fp_mult_if.slave   bus
);

  localparam int PW = 2 * MAN_W + 2;   // significand product width
  localparam int XW = EXP_W + 2;       // signed working exponent width

  localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] E_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] E_ONE = XW'(1);

  // Special-case code resolved in UNPACK, applied in ROUND
  localparam logic [2:0] SP_NONE = 3'd0;
  localparam logic [2:0] SP_NAN  = 3'd1;
  localparam logic [2:0] SP_INV  = 3'd2;
  localparam logic [2:0] SP_INF  = 3'd3;
  localparam logic [2:0] SP_ZERO = 3'd4;

  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND} state_t;

  state_t                 state;
  logic [W-1:0]           a_r, b_r;
  logic                   rnd_r;
  logic                   sign_r;
  logic [2:0]             spec_r;
  logic [EXP_W-1:0]       ea_r, eb_r;
  logic [MAN_W:0]         sig_a_r, sig_b_r;
  logic [PW-1:0]          prod_r;
  logic signed [XW-1:0]   exp_r;
  logic signed [XW-1:0]   exp_n_r;
  logic [MAN_W-1:0]       frac_r;
  logic                   guard_r, sticky_r;

  // ---------------- UNPACK: classification ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [2:0]       spec_nx;

  always_comb begin
    ea     = a_r[W-2:MAN_W];
    eb     = b_r[W-2:MAN_W];
    fa     = a_r[MAN_W-1:0];
    fb     = b_r[MAN_W-1:0];
    // exponent field zero covers both true zero and flushed subnormals
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);

    spec_nx = SP_NONE;
    if (a_nan || b_nan)                          spec_nx = SP_NAN;
    else if ((a_zero && b_inf) || (a_inf && b_zero)) spec_nx = SP_INV;
    else if (a_inf || b_inf)                     spec_nx = SP_INF;
    else if (a_zero || b_zero)                   spec_nx = SP_ZERO;
  end

  // ---------------- NORM: align product to 1.f ----------------
  // shifted drops the leading one; its top MAN_W bits are the fraction
  logic [PW-2:0]        shifted;
  logic signed [XW-1:0] exp_n_nx;

  always_comb begin
    shifted  = prod_r[PW-1] ? prod_r[PW-2:0] : {prod_r[PW-3:0], 1'b0};
    exp_n_nx = exp_r + $signed({{(XW-1){1'b0}}, prod_r[PW-1]});
  end

  // ---------------- ROUND: rounding and final packing ----------------
  logic                 inc;
  logic                 carry;
  logic [MAN_W-1:0]     frac_rnd;
  logic signed [XW-1:0] exp_rnd;
  logic                 inexact;
  logic [W-1:0]         res_nx;
  logic [4:0]           flg_nx;

  always_comb begin
    inc              = ~rnd_r & guard_r & (sticky_r | frac_r[0]);
    {carry, frac_rnd} = {1'b0, frac_r} + {{MAN_W{1'b0}}, inc};
    // carry-out means the fraction wrapped to zero: 1.111.. + ulp = 10.000..
    exp_rnd          = exp_n_r + $signed({{(XW-1){1'b0}}, carry});
    inexact          = guard_r | sticky_r;

    res_nx = {sign_r, exp_rnd[EXP_W-1:0], frac_rnd};
    flg_nx = {3'b000, inexact, 1'b0};
    if (exp_rnd >= E_MAX) begin
      res_nx = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_nx = 5'b01010;
    end else if (exp_rnd < E_ONE) begin
      res_nx = {sign_r, {(W-1){1'b0}}};
      flg_nx = 5'b00111;
    end

    case (spec_r)
      SP_NAN: begin
        res_nx = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flg_nx = 5'b00000;
      end
      SP_INV: begin
        res_nx = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flg_nx = 5'b10000;
      end
      SP_INF: begin
        res_nx = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flg_nx = 5'b00000;
      end
      SP_ZERO: begin
        res_nx = {sign_r, {(W-1){1'b0}}};
        flg_nx = 5'b00001;
      end
      default: ;
    endcase
  end

  // ---------------- control and datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      rnd_r      <= 1'b0;
      sign_r     <= 1'b0;
      spec_r     <= SP_NONE;
      ea_r       <= '0;
      eb_r       <= '0;
      sig_a_r    <= '0;
      sig_b_r    <= '0;
      prod_r     <= '0;
      exp_r      <= '0;
      exp_n_r    <= '0;
      frac_r     <= '0;
      guard_r    <= 1'b0;
      sticky_r   <= 1'b0;
      bus.result <= '0;
      bus.flags  <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_r      <= bus.a_in;
            b_r      <= bus.b_in;
            rnd_r    <= bus.rnd_mode;
            bus.busy <= 1'b1;
            state    <= UNPACK;
          end
        end
        UNPACK: begin
          sign_r  <= a_r[W-1] ^ b_r[W-1];
          spec_r  <= spec_nx;
          ea_r    <= ea;
          eb_r    <= eb;
          sig_a_r <= {1'b1, fa};
          sig_b_r <= {1'b1, fb};
          state   <= MULT;
        end
        MULT: begin
          prod_r <= PW'(sig_a_r) * PW'(sig_b_r);
          exp_r  <= $signed({2'b00, ea_r}) + $signed({2'b00, eb_r}) - BIAS;
          state  <= NORM;
        end
        NORM: begin
          frac_r   <= shifted[PW-2 -: MAN_W];
          guard_r  <= shifted[MAN_W];
          sticky_r <= |shifted[MAN_W-1:0];
          exp_n_r  <= exp_n_nx;
          state    <= ROUND;
        end
        ROUND: begin
          bus.result <= res_nx;
          bus.flags  <= flg_nx;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_param.sv
// tb/tb_fp_mult_param.sv - directed self-checking bench for fp_mult_param

module tb_fp_mult_param;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fp_mult_if #(.W(32)) bus32 ();
  fp_mult_if #(.W(16)) bus16 ();

  fp_mult_param #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  fp_mult_param #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One binary32 operation; lat = edges from acceptance to done (-1 on timeout)
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic rnd,
                       output logic [31:0] res, output logic [4:0] flg,
                       output int lat, output logic bsy);
    @(negedge clk);
    bus32.a_in = a; bus32.b_in = b; bus32.rnd_mode = rnd; bus32.start = 1'b1;
    @(posedge clk); #1;
    bsy = bus32.busy;
    bus32.start = 1'b0;
    bus32.a_in = $urandom; bus32.b_in = $urandom; bus32.rnd_mode = ~rnd;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus32.done) begin lat = i; break; end
    end
    res = bus32.result;
    flg = bus32.flags;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic [4:0] flg, output int lat);
    @(negedge clk);
    bus16.a_in = a; bus16.b_in = b; bus16.rnd_mode = 1'b0; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.a_in = $urandom; bus16.b_in = $urandom;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus16.done) begin lat = i; break; end
    end
    res = bus16.result;
    flg = bus16.flags;
  endtask

  logic [31:0] r32;
  logic [15:0] r16;
  logic [4:0]  fl;
  int          lat;
  logic        bsy;
  logic [31:0] op_a [3];
  logic [31:0] op_b [3];
  logic [31:0] op_r [3];
  int          dcyc [3];
  logic [31:0] dres [3];
  int          n_done, idx, cyc, seen;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus32.start = 1'b0; bus32.rnd_mode = 1'b0; bus32.a_in = '0; bus32.b_in = '0;
    bus16.start = 1'b0; bus16.rnd_mode = 1'b0; bus16.a_in = '0; bus16.b_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_result", bus32.result, 32'h0);
    chk("reset_flags",  32'(bus32.flags), 32'h0);
    chk("reset_busy",   32'(bus32.busy), 32'h0);
    chk("reset_done",   32'(bus32.done), 32'h0);
    rst_n = 1'b1;

    // 1.5 * 2.0 = 3.0
    run32(32'h3FC00000, 32'h40000000, 1'b0, r32, fl, lat, bsy);
    chk("basic_latency", 32'(lat), 32'd4);
    chk("basic_busy",    32'(bsy), 32'd1);
    chk("basic_result",  r32, 32'h40400000);
    chk("basic_flags",   32'(fl), 32'(5'b00000));
    chk("basic_busy_at_done", 32'(bus32.busy), 32'd0);

    // (1+2^-23) * 1.5: guard=1, sticky=0, lsb=1
    run32(32'h3F800001, 32'h3FC00000, 1'b0, r32, fl, lat, bsy);
    chk("rne_result", r32, 32'h3FC00002);
    chk("rne_flags",  32'(fl), 32'(5'b00010));
    run32(32'h3F800001, 32'h3FC00000, 1'b1, r32, fl, lat, bsy);
    chk("trunc_result", r32, 32'h3FC00001);
    chk("trunc_flags",  32'(fl), 32'(5'b00010));

    run32(32'h7F000000, 32'h7F000000, 1'b0, r32, fl, lat, bsy);
    chk("ovf_result", r32, 32'h7F800000);
    chk("ovf_flags",  32'(fl), 32'(5'b01010));
    run32(32'h7F000000, 32'h7F000000, 1'b1, r32, fl, lat, bsy);
    chk("ovf_trunc_result", r32, 32'h7F800000);
    run32(32'h00800000, 32'h3F000000, 1'b0, r32, fl, lat, bsy);
    chk("udf_result", r32, 32'h00000000);
    chk("udf_flags",  32'(fl), 32'(5'b00111));

    run32(32'h00000000, 32'h7F800000, 1'b0, r32, fl, lat, bsy);
    chk("zero_inf_result", r32, 32'h7FC00000);
    chk("zero_inf_flags",  32'(fl), 32'(5'b10000));
    run32(32'hFF800000, 32'h40000000, 1'b0, r32, fl, lat, bsy);
    chk("ninf_result", r32, 32'hFF800000);
    chk("ninf_flags",  32'(fl), 32'(5'b00000));
    run32(32'h80000000, 32'h3F800000, 1'b0, r32, fl, lat, bsy);
    chk("nzero_result", r32, 32'h80000000);
    chk("nzero_flags",  32'(fl), 32'(5'b00001));
    run32(32'h7FC12345, 32'h00000000, 1'b0, r32, fl, lat, bsy);
    chk("nan_result", r32, 32'h7FC00000);
    chk("nan_flags",  32'(fl), 32'(5'b00000));

    // Back-to-back with start held high; operands scrambled while busy
    op_a[0] = 32'h40000000; op_b[0] = 32'h3FC00000; op_r[0] = 32'h40400000;
    op_a[1] = 32'h40000000; op_b[1] = 32'h40000000; op_r[1] = 32'h40800000;
    op_a[2] = 32'h3F800000; op_b[2] = 32'hC0000000; op_r[2] = 32'hC0000000;
    for (int i = 0; i < 3; i++) begin dcyc[i] = -1; dres[i] = '0; end
    @(negedge clk);
    bus32.rnd_mode = 1'b0;
    bus32.a_in = op_a[0]; bus32.b_in = op_b[0]; bus32.start = 1'b1;
    n_done = 0; idx = 1; cyc = 0;
    while (n_done < 3 && cyc < 40) begin
      @(posedge clk); cyc++; #1;
      if (bus32.done) begin
        dcyc[n_done] = cyc;
        dres[n_done] = bus32.result;
        n_done++;
      end
      @(negedge clk);
      if (bus32.done) begin
        if (idx < 3) begin
          bus32.a_in = op_a[idx]; bus32.b_in = op_b[idx]; idx++;
        end else begin
          bus32.start = 1'b0;
        end
      end else begin
        bus32.a_in = $urandom; bus32.b_in = $urandom;
      end
    end
    bus32.start = 1'b0;
    chk("b2b_count",  32'(n_done), 32'd3);
    chk("b2b_first",  32'(dcyc[0]), 32'd5);
    chk("b2b_gap1",   32'(dcyc[1] - dcyc[0]), 32'd5);
    chk("b2b_gap2",   32'(dcyc[2] - dcyc[1]), 32'd5);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_result%0d", i), dres[i], op_r[i]);
    repeat (6) @(posedge clk);
    #1 chk("b2b_idle_busy", 32'(bus32.busy), 32'd0);

    // Reset while the operation sits in MULT
    @(negedge clk);
    bus32.a_in = 32'h3FC00000; bus32.b_in = 32'h40000000; bus32.start = 1'b1;
    @(posedge clk); #1 bus32.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", bus32.result, 32'h0);
    chk("abort_flags",  32'(bus32.flags), 32'h0);
    chk("abort_busy",   32'(bus32.busy), 32'd0);
    chk("abort_done",   32'(bus32.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus32.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run32(32'h3FC00000, 32'h40000000, 1'b0, r32, fl, lat, bsy);
    chk("post_abort_latency", 32'(lat), 32'd4);
    chk("post_abort_result",  r32, 32'h40400000);

    // binary16 instance
    run16(16'h3E00, 16'h4000, r16, fl, lat);
    chk("h_latency", 32'(lat), 32'd4);
    chk("h_result",  32'(r16), 32'h4200);
    chk("h_flags",   32'(fl), 32'(5'b00000));
    run16(16'h7BFF, 16'h7BFF, r16, fl, lat);
    chk("h_ovf_result", 32'(r16), 32'h7C00);
    chk("h_ovf_flags",  32'(fl), 32'(5'b01010));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
